lpif_asym_slave_rx_link: RTL and testbench
==========================================

// Module: lpif_asym_slave_rx_link
// PURPOSE
//  Parametrised downstream receive link for asymmetric LPIF slave tops. Replaces the
//  bypassed RX FIFO path with an online sequencer, a multi-channel push-alignment
//  check and a DEPTH-entry elastic buffer. It sits between the PHY concat block
//  (rx_downstream_data) and the LPIF user-interface name block (rxfifo_downstream_data).
// PARAMETERS
//  DATA_W      580  width of one downstream word (all channels concatenated)
//  NUM_CHAN    2    PHY channels contributing to one word; each has its own push
//  FIFO_DEPTH  8    buffer entries; power of 2, 2..128
//  DELAY_W     16   width of delay_x_value
// PORTS
//  clk_wr          in   1                  single clock
//  rst_wr_n        in   1                  asynchronous, active-low reset
//  rx_online       in   1                  link-layer RX enable
//  delay_x_value   in   DELAY_W            cycles of hold-off after rx_online rises
//  rx_push         in   NUM_CHAN           per-channel word-valid from concat block
//  rx_mrk          in   1                  word-alignment marker qualifying rx_push
//  rx_data         in   DATA_W             downstream word from concat block
//  dstrm_ready     in   1                  consumer takes head word when dstrm_valid=1
//  dstrm_valid     out  1                  head word present
//  dstrm_data      out  DATA_W             head word
//  rx_online_delay out  1                  1 only in state ONLINE
//  debug_clr       in   1                  clears sticky flags and drop counter
//  debug_status    out  32                 status word, layout below
// BEHAVIOUR
//  Reset: state=OFFLINE, FIFO empty, dstrm_valid=0, dstrm_data=0, rx_online_delay=0,
//   debug_status=0, all counters 0.
//  FSM (registered, transitions on clk_wr):
//   OFFLINE: rx_online=1 -> load dly_cnt=delay_x_value; go DELAY (or ALIGN if value 0).
//   DELAY:   dly_cnt decrements each cycle; at dly_cnt==1 -> ALIGN.
//   ALIGN:   all rx_push bits=1 with rx_mrk=1 -> ONLINE; that word IS written.
//   ONLINE:  normal operation.
//   Any state: rx_online=0 -> OFFLINE next cycle, FIFO flushed (ptrs/count=0),
//   dstrm_valid=0 next cycle. Sticky flags and drop counter are NOT flushed.
//  Push (ONLINE or ALIGN-exit cycle only): word written when rx_push all ones.
//   rx_push neither all-zero nor all-ones -> word dropped, desync sticky set.
//   Push in OFFLINE/DELAY/ALIGN (without marker) -> ignored silently.
//  Full: push with count==FIFO_DEPTH and no pop -> word dropped, overflow sticky set,
//   drop_cnt++ (saturates at 16'hFFFF). Push+pop on full -> both proceed, no drop.
//  Pop: dstrm_valid && dstrm_ready -> rd_ptr++. dstrm_ready with empty FIFO -> no-op.
//  Latency: word pushed in cycle N is on dstrm_data with dstrm_valid=1 in N+1
//   (when FIFO was empty). dstrm_data is the read-mux of mem[rd_ptr]; it is held
//   when empty and is not cleared.
//  Pointers: log2(FIFO_DEPTH) bits, natural wrap; count is log2(FIFO_DEPTH)+1 bits.
//  debug_status: [31:30] state (0 OFF,1 DLY,2 ALN,3 ON), [29] overflow sticky,
//   [28] desync sticky, [27] rx_online_delay, [26:24] 0, [23:16] count zero-extended,
//   [15:0] drop_cnt. Registered; reflects values of the previous cycle.
//  debug_clr: clears [29],[28],[15:0] next cycle. Simultaneous with a drop -> clear wins.
//  Reset mid-operation: asynchronous return to reset values; no partial word is retained.
// STRUCTURE
//  Package lpif_rx_link_pkg: state enum rx_link_st_e {OFFLINE,DELAY,ALIGN,ONLINE},
//   debug_status bit-position localparams.
//  Sub-module lpif_sync_fifo #(WIDTH,DEPTH): single-clock FIFO with push/pop/flush,
//   full/empty/count. The FSM, push qualification and status logic stay in the top.
// TESTING
//  1 rx_online=1, delay_x=5, rx_push=2'b11 without rx_mrk -> rx_online_delay rises
//    only after the first marker word (>=6 cycles); unmarked words are never output.
//  2 ONLINE, push 8 words, ready=0, push a 9th -> count=8, overflow=1, drop_cnt=1;
//    drain -> words 0..7 in order.
//  3 Full FIFO, push+pop in the same cycle -> count stays 8, no drop, data order kept.
//  4 ONLINE, rx_push=2'b01 -> word dropped, desync=1, count unchanged; debug_clr=1 ->
//    [29:28]=0, drop_cnt=0.
//  5 rx_online drops with 3 words buffered -> next cycle dstrm_valid=0, state=OFFLINE,
//    count=0; re-online realigns from ALIGN.
//  6 delay_x=0 -> ALIGN one cycle after rx_online; async reset mid-burst -> all outputs 0.

Source files
------------

// File: rtl/lpif_rx_link_pkg.sv
// Shared types and debug_status field positions
// for the asymmetric LPIF slave receive link.
package lpif_rx_link_pkg;

    typedef enum logic [1:0] {
        OFFLINE = 2'd0,
        DELAY   = 2'd1,
        ALIGN   = 2'd2,
        ONLINE  = 2'd3
    } rx_link_st_e;

    localparam int ST_MSB   = 31;
    localparam int ST_LSB   = 30;
    localparam int OVF_BIT  = 29;
    localparam int DSY_BIT  = 28;
    localparam int OND_BIT  = 27;
    localparam int CNT_MSB  = 23;
    localparam int CNT_LSB  = 16;
    localparam int DROP_MSB = 15;

endpackage

// File: rtl/lpif_sync_fifo.sv
// Single-clock elastic buffer with flush; head word
// is presented combinationally from mem[rd_ptr].
module lpif_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             wr_en, rd_en;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // a full buffer still accepts a word when the head leaves in the same cycle
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(wr_en) - CW'(rd_en);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (wr_en && !flush) mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/lpif_asym_slave_rx_link.sv
// Downstream receive link: online sequencer, multi-channel
// push alignment check and elastic buffer with debug status.
module lpif_asym_slave_rx_link
    import lpif_rx_link_pkg::*;
#(
    parameter int DATA_W     = 580,
    parameter int NUM_CHAN   = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int DELAY_W    = 16
) (
    input  logic                clk_wr,
    input  logic                rst_wr_n,
    input  logic                rx_online,
    input  logic [DELAY_W-1:0]  delay_x_value,
    input  logic [NUM_CHAN-1:0] rx_push,
    input  logic                rx_mrk,
    input  logic [DATA_W-1:0]   rx_data,
    input  logic                dstrm_ready,
    output logic                dstrm_valid,
    output logic [DATA_W-1:0]   dstrm_data,
    output logic                rx_online_delay,
    input  logic                debug_clr,
    output logic [31:0]         debug_status
);

    localparam int AW = $clog2(FIFO_DEPTH);

    rx_link_st_e        state_q, state_d;
    logic [DELAY_W-1:0] dly_q, dly_d;
    logic               ovf_q, ovf_d;
    logic               dsy_q, dsy_d;
    logic [15:0]        drop_q, drop_d;
    logic [31:0]        status_q, status_d;

    logic               all_push, any_push;
    logic               wr_win, wr_req, pop, ovf_drop, dsy_drop;
    logic               full, empty;
    logic [AW:0]        count;
    logic [7:0]         cnt8;

    assign all_push = &rx_push;
    assign any_push = |rx_push;

    // the marker word that completes alignment is itself stored
    assign wr_win   = rx_online &&
                      ((state_q == ONLINE) ||
                       (state_q == ALIGN && all_push && rx_mrk));
    assign wr_req   = wr_win && all_push;
    assign dsy_drop = rx_online && (state_q == ONLINE) &&
                      any_push && !all_push;
    assign pop      = dstrm_valid && dstrm_ready;
    assign ovf_drop = wr_req && full && !pop;

    lpif_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_wr),
        .rst_n (rst_wr_n),
        .push  (wr_req),
        .pop   (pop),
        .flush (!rx_online),
        .wdata (rx_data),
        .rdata (dstrm_data),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign dstrm_valid = !empty;

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            state_q <= OFFLINE;
            dly_q   <= '0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        if (!rx_online) begin
            state_d = OFFLINE;
        end else begin
            unique case (state_q)
                OFFLINE: begin
                    dly_d   = delay_x_value;
                    state_d = (delay_x_value == '0) ? ALIGN : DELAY;
                end
                DELAY: begin
                    dly_d = dly_q - DELAY_W'(1);
                    if (dly_q <= DELAY_W'(1)) state_d = ALIGN;
                end
                ALIGN: begin
                    if (all_push && rx_mrk) state_d = ONLINE;
                end
                ONLINE: begin
                    state_d = ONLINE;
                end
            endcase
        end
    end

    always_comb begin
        rx_online_delay = (state_q == ONLINE);
    end

    assign cnt8 = 8'(count);

    always_comb begin
        ovf_d  = ovf_q | ovf_drop;
        dsy_d  = dsy_q | dsy_drop;
        drop_d = drop_q;
        if (ovf_drop && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
        if (debug_clr) begin
            ovf_d  = 1'b0;
            dsy_d  = 1'b0;
            drop_d = '0;
        end
    end

    always_comb begin
        status_d                    = '0;
        status_d[ST_MSB:ST_LSB]     = state_q;
        status_d[OVF_BIT]           = ovf_q;
        status_d[DSY_BIT]           = dsy_q;
        status_d[OND_BIT]           = rx_online_delay;
        status_d[CNT_MSB:CNT_LSB]   = cnt8;
        status_d[DROP_MSB:0]        = drop_q;
    end

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            ovf_q    <= 1'b0;
            dsy_q    <= 1'b0;
            drop_q   <= '0;
            status_q <= '0;
        end else begin
            ovf_q    <= ovf_d;
            dsy_q    <= dsy_d;
            drop_q   <= drop_d;
            status_q <= status_d;
        end
    end

    assign debug_status = status_q;

endmodule

// File: tb/tb_lpif_asym_slave_rx_link.sv
// Directed + randomized bench for lpif_asym_slave_rx_link
// against a queue-based reference model.
module tb_lpif_asym_slave_rx_link;

    localparam int DW    = 580;
    localparam int NC    = 2;
    localparam int DEPTH = 8;
    localparam int DLW   = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            rx_online;
    logic [DLW-1:0]  dly;
    logic [NC-1:0]   rx_push;
    logic            rx_mrk;
    logic [DW-1:0]   rx_data;
    logic            ready;
    logic            dclr;
    logic            dstrm_valid;
    logic [DW-1:0]   dstrm_data;
    logic            online_dly;
    logic [31:0]     status;

    always #5 clk = ~clk;

    lpif_asym_slave_rx_link #(
        .DATA_W     (DW),
        .NUM_CHAN   (NC),
        .FIFO_DEPTH (DEPTH),
        .DELAY_W    (DLW)
    ) dut (
        .clk_wr          (clk),
        .rst_wr_n        (rst_n),
        .rx_online       (rx_online),
        .delay_x_value   (dly),
        .rx_push         (rx_push),
        .rx_mrk          (rx_mrk),
        .rx_data         (rx_data),
        .dstrm_ready     (ready),
        .dstrm_valid     (dstrm_valid),
        .dstrm_data      (dstrm_data),
        .rx_online_delay (online_dly),
        .debug_clr       (dclr),
        .debug_status    (status)
    );

    // reference model: state number, hold-off count, queue, flags
    int            m_st;
    int            m_dly;
    logic [DW-1:0] q[$];
    bit            m_ovf;
    bit            m_des;
    int            m_drop;
    logic [31:0]   m_stat;

    int cmps = 0;
    int errs = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        cmps++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_word();
        logic [DW+31:0] t;
        t = '0;
        for (int i = 0; i < DW; i += 32) t[i +: 32] = $urandom;
        return t[DW-1:0];
    endfunction

    task automatic model_reset();
        m_st = 0; m_dly = 0; q.delete();
        m_ovf = 0; m_des = 0; m_drop = 0; m_stat = '0;
    endtask

    task automatic model_edge();
        bit pop, all, win;
        pop = (q.size() != 0) && ready;
        all = (rx_push == {NC{1'b1}});
        m_stat = {m_st[1:0], m_ovf, m_des, (m_st == 3), 3'b000,
                  8'(q.size()), 16'(m_drop)};
        if (!rx_online) begin
            m_st = 0;
            q.delete();
        end else begin
            win = (m_st == 3) || (m_st == 2 && all && rx_mrk);
            if (win && all) begin
                if (q.size() == DEPTH && !pop) begin
                    m_ovf = 1;
                    if (m_drop < 65535) m_drop++;
                end else begin
                    if (pop) void'(q.pop_front());
                    pop = 0;
                    q.push_back(rx_data);
                end
            end else if (m_st == 3 && rx_push != 0) begin
                m_des = 1;
            end
            if (pop) void'(q.pop_front());
            case (m_st)
                0: begin m_dly = int'(dly); m_st = (dly == 0) ? 2 : 1; end
                1: begin if (m_dly == 1) m_st = 2; m_dly--; end
                2: if (all && rx_mrk) m_st = 3;
                default: ;
            endcase
        end
        if (dclr) begin m_ovf = 0; m_des = 0; m_drop = 0; end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("valid", dstrm_valid, q.size() != 0);
        if (q.size() != 0) chk("data", dstrm_data, q[0]);
        chk("online_dly", online_dly, m_st == 3);
        chk("status", status, m_stat);
    endtask

    task automatic idle();
        rx_push = '0; rx_mrk = 0; dclr = 0;
    endtask

    task automatic push_word(input logic [NC-1:0] p);
        rx_push = p; rx_data = rnd_word(); step();
    endtask

    initial begin
        int rise;
        int r;
        rst_n = 0; rx_online = 0; dly = '0; rx_push = '0; rx_mrk = 0;
        rx_data = '0; ready = 0; dclr = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", dstrm_valid, 0);
        chk("rst_data", dstrm_data, 0);
        chk("rst_online", online_dly, 0);
        chk("rst_status", status, 0);
        rst_n = 1;
        step();

        // unmarked words during hold-off/align are never output
        rx_online = 1; dly = 16'd5; rx_mrk = 0;
        rise = -1;
        for (int i = 0; i < 10; i++) begin
            push_word(2'b11);
            if (online_dly && rise < 0) rise = i;
        end
        chk("t1_no_early_online", rise, -1);
        rx_mrk = 1; push_word(2'b11);
        chk("t1_online_after_mrk", online_dly, 1);
        chk("t1_one_word", status[23:16], 0);
        idle(); ready = 1; step(); step();

        // overflow on ninth word, then in-order drain
        ready = 0;
        for (int i = 0; i < 9; i++) push_word(2'b11);
        idle(); step(); step();
        chk("t2_count", status[23:16], 8);
        chk("t2_ovf", status[29], 1);
        chk("t2_drop", status[15:0], 1);
        ready = 1;
        for (int i = 0; i < 9; i++) step();
        chk("t2_empty", dstrm_valid, 0);

        // push+pop while full
        ready = 0;
        for (int i = 0; i < 8; i++) push_word(2'b11);
        ready = 1;
        for (int i = 0; i < 6; i++) push_word(2'b11);
        idle(); ready = 0; step(); step();
        chk("t3_count", status[23:16], 8);
        chk("t3_drop", status[15:0], 1);
        ready = 1;
        for (int i = 0; i < 9; i++) step();

        // partial push -> desync, then clear
        push_word(2'b01);
        idle(); step(); step();
        chk("t4_desync", status[28], 1);
        chk("t4_count", status[23:16], 0);
        dclr = 1; step(); dclr = 0; step(); step();
        chk("t4_clr_flags", status[29:28], 0);
        chk("t4_clr_drop", status[15:0], 0);

        // link drop with words buffered, then realign
        ready = 0;
        for (int i = 0; i < 3; i++) push_word(2'b11);
        idle(); rx_online = 0; step();
        chk("t5_valid_off", dstrm_valid, 0);
        step();
        chk("t5_state_off", status[31:30], 0);
        chk("t5_count0", status[23:16], 0);
        rx_online = 1; dly = 16'd2;
        repeat (3) step();
        rx_mrk = 0; push_word(2'b11);
        chk("t5_align", status[31:30], 2);
        rx_mrk = 1; push_word(2'b11);
        chk("t5_realigned", online_dly, 1);
        idle(); ready = 1; step();

        // zero hold-off: ALIGN directly
        rx_online = 0; step();
        dly = '0; rx_online = 1; step(); step();
        chk("t6_align_now", status[31:30], 2);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            rx_push = (r < 6) ? 2'b11 : (r == 6) ? 2'b01 : (r == 7) ? 2'b10 : 2'b00;
            rx_mrk = 1'($urandom_range(0, 1));
            rx_data = rnd_word();
            ready = ($urandom_range(0, 2) != 0);
            dclr = ($urandom_range(0, 29) == 0);
            rx_online = ($urandom_range(0, 59) != 0);
            dly = 16'($urandom_range(0, 3));
            step();
        end

        // asynchronous reset mid-burst
        rx_online = 1; ready = 0;
        for (int i = 0; i < 3; i++) push_word(2'b11);
        rst_n = 0;
        #2;
        model_reset();
        chk("t6_rst_valid", dstrm_valid, 0);
        chk("t6_rst_data", dstrm_data, 0);
        chk("t6_rst_online", online_dly, 0);
        chk("t6_rst_status", status, 0);
        idle(); rx_online = 0;
        @(negedge clk);
        rst_n = 1;
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end

endmodule
